// File: rtl/mdu_hilo_if.sv
// Execute-stage port bundle between the pipeline and the multiply/divide unit.
// The pipeline side drives operands and control; the MDU returns busy and HI/LO data.
interface mdu_hilo_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        req;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDU_out;

  modport master (
    output start, op, A, B, req,
    input  busy, HI, LO, MDU_out
  );

  modport slave (
    input  start, op, A, B, req,
    output busy, HI, LO, MDU_out
  );
endinterface

// File: rtl/mdu_hilo.sv
// Multiply/divide unit with architectural HI/LO registers and fixed multi-cycle latency.
// The result is computed at start and held in temp registers until the latency expires.
module mdu_hilo #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_hilo_if.slave bus
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam int unsigned DW         = 32;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [DW-1:0]     thi_q, thi_d, tlo_q, tlo_d;
  logic              tvalid_q, tvalid_d;

  logic              is_signed, is_div, start_ok;
  logic              a_neg, b_neg;
  logic [2*DW-1:0]   a_ext, b_ext, prod;
  logic [DW-1:0]     a_mag, b_mag, b_div, q_mag, r_mag, div_q, div_r;

  // Signed ops are the even opcodes; divide is op[1]. Division is done on magnitudes.
  always_comb begin
    is_signed = ~bus.op[0];
    is_div    = bus.op[1];
    start_ok  = bus.start & ~bus.req & ~bus.op[2];
    a_ext     = is_signed ? {{DW{bus.A[DW-1]}}, bus.A} : {{DW{1'b0}}, bus.A};
    b_ext     = is_signed ? {{DW{bus.B[DW-1]}}, bus.B} : {{DW{1'b0}}, bus.B};
    prod      = a_ext * b_ext;
    a_neg     = is_signed & bus.A[DW-1];
    b_neg     = is_signed & bus.B[DW-1];
    a_mag     = a_neg ? (~bus.A + DW'(1)) : bus.A;
    b_mag     = b_neg ? (~bus.B + DW'(1)) : bus.B;
    // Keep the divider X-free on a zero divisor; that result is discarded anyway.
    b_div     = (b_mag == '0) ? DW'(1) : b_mag;
    q_mag     = a_mag / b_div;
    r_mag     = a_mag % b_div;
    div_q     = (a_neg ^ b_neg) ? (~q_mag + DW'(1)) : q_mag;
    div_r     = a_neg ? (~r_mag + DW'(1)) : r_mag;
  end

  // Next-state logic: start/mthi/mtlo only act in IDLE, RUN always runs to completion.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    thi_d    = thi_q;
    tlo_d    = tlo_q;
    tvalid_d = tvalid_q;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          thi_d    = is_div ? div_r : prod[2*DW-1:DW];
          tlo_d    = is_div ? div_q : prod[DW-1:0];
          tvalid_d = ~(is_div & (bus.B == '0));
          cnt_d    = is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
          state_d  = RUN;
        end else if (~bus.req && bus.op == 3'd4) begin
          hi_d = bus.A;
        end else if (~bus.req && bus.op == 3'd5) begin
          lo_d = bus.A;
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          if (tvalid_q) begin
            hi_d = thi_q;
            lo_d = tlo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      thi_q    <= '0;
      tlo_q    <= '0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      thi_q    <= thi_d;
      tlo_q    <= tlo_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign bus.busy    = bus.start | (state_q != IDLE);
  assign bus.HI      = hi_q;
  assign bus.LO      = lo_q;
  assign bus.MDU_out = (bus.op == 3'd6) ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Randomized and directed bench for mdu_hilo against an arithmetic HI/LO model.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_mdu_hilo;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  mdu_hilo_if bus ();

  mdu_hilo #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Architectural result of one MDU/move instruction, from plain 64-bit arithmetic.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] hi, inout logic [31:0] lo);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
      3'd1: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
      3'd2: if (b != 0) begin sq = sa / sb; sr = sa % sb; lo = sq[31:0]; hi = sr[31:0]; end
      3'd3: if (b != 0) begin lo = a / b; hi = a % b; end
      3'd4: hi = a;
      3'd5: lo = a;
      default: ;
    endcase
  endfunction

  task automatic idle_inputs();
    bus.start = 1'b0;
    bus.op    = 3'd6;
    bus.req   = 1'b0;
  endtask

  // Issue one start for a cycle and count how many cycles busy stays high.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int nbusy);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b; bus.req = 1'b0;
    #1;
    nbusy = bus.busy ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      idle_inputs();
      #1;
      if (!bus.busy) break;
      nbusy++;
    end
  endtask

  task automatic move_op(input logic [2:0] op, input logic [31:0] a, input logic r);
    @(negedge clk);
    bus.start = 1'b0; bus.op = op; bus.A = a; bus.req = r;
    @(negedge clk);
    idle_inputs();
    #1;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    idle_inputs();
    bus.A = '0; bus.B = '0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (bus.HI !== 32'h0 || bus.LO !== 32'h0) begin bad++; $display("FAIL reset_hilo: got %h/%h want 0/0", bus.HI, bus.LO); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    rst_n = 1'b1;
    // Start a mult, then reset in the middle of RUN.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.A = 32'd3; bus.B = 32'd4;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_midrun_busy: got %b want 0", bus.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    total++; if (bus.HI !== 32'h0 || bus.LO !== 32'h0) begin bad++; $display("FAIL reset_no_late_update: got %h/%h want 0/0", bus.HI, bus.LO); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_idle_after: got %b want 0", bus.busy); end
    exp_hi = '0; exp_lo = '0;
    n = 0;
  endtask

  task automatic test_mult();
    int n;
    run_op(3'd0, 32'hFFFF_FFFF, 32'd2, n);
    model(3'd0, 32'hFFFF_FFFF, 32'd2, exp_hi, exp_lo);
    total++; if (n != MULT_N) begin bad++; $display("FAIL mult_busy_len: got %0d want %0d", n, MULT_N); end
    total++; if (bus.HI !== 32'hFFFF_FFFF || bus.LO !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mult_signed: got %h/%h want ffffffff/fffffffe", bus.HI, bus.LO); end
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, n);
    model(3'd1, 32'hFFFF_FFFF, 32'd2, exp_hi, exp_lo);
    total++; if (n != MULT_N) begin bad++; $display("FAIL multu_busy_len: got %0d want %0d", n, MULT_N); end
    total++; if (bus.HI !== 32'h1 || bus.LO !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu: got %h/%h want 00000001/fffffffe", bus.HI, bus.LO); end
  endtask

  task automatic test_div();
    int n;
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, n);
    model(3'd2, 32'hFFFF_FFF9, 32'd2, exp_hi, exp_lo);
    total++; if (n != DIV_N) begin bad++; $display("FAIL div_busy_len: got %0d want %0d", n, DIV_N); end
    total++; if (bus.HI !== 32'hFFFF_FFFF || bus.LO !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_neg: got %h/%h want ffffffff/fffffffd", bus.HI, bus.LO); end
    run_op(3'd3, 32'd7, 32'd2, n);
    model(3'd3, 32'd7, 32'd2, exp_hi, exp_lo);
    total++; if (bus.HI !== 32'd1 || bus.LO !== 32'd3) begin bad++; $display("FAIL divu: got %h/%h want 1/3", bus.HI, bus.LO); end
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, n);
    model(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, exp_hi, exp_lo);
    total++; if (bus.HI !== 32'h0 || bus.LO !== 32'h8000_0000) begin bad++; $display("FAIL div_overflow: got %h/%h want 0/80000000", bus.HI, bus.LO); end
  endtask

  task automatic test_div_zero();
    int n;
    move_op(3'd4, 32'h11, 1'b0);
    move_op(3'd5, 32'h22, 1'b0);
    total++; if (bus.HI !== 32'h11 || bus.LO !== 32'h22) begin bad++; $display("FAIL mthi_mtlo: got %h/%h want 11/22", bus.HI, bus.LO); end
    run_op(3'd2, 32'd1234, 32'd0, n);
    total++; if (n != DIV_N) begin bad++; $display("FAIL divzero_busy_len: got %0d want %0d", n, DIV_N); end
    total++; if (bus.HI !== 32'h11 || bus.LO !== 32'h22) begin bad++; $display("FAIL divzero_hold: got %h/%h want 11/22", bus.HI, bus.LO); end
    exp_hi = 32'h11; exp_lo = 32'h22;
    bus.op = 3'd6; #1;
    total++; if (bus.MDU_out !== exp_hi) begin bad++; $display("FAIL mfhi: got %h want %h", bus.MDU_out, exp_hi); end
    bus.op = 3'd7; #1;
    total++; if (bus.MDU_out !== exp_lo) begin bad++; $display("FAIL mflo: got %h want %h", bus.MDU_out, exp_lo); end
    idle_inputs();
  endtask

  task automatic test_flush();
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.A = 32'd9; bus.B = 32'd9; bus.req = 1'b1;
    #1;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL flush_busy_now: got %b want 1", bus.busy); end
    @(negedge clk);
    idle_inputs();
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL flush_busy_next: got %b want 0", bus.busy); end
    repeat (MULT_N) @(negedge clk);
    #1;
    total++; if (bus.HI !== exp_hi || bus.LO !== exp_lo) begin bad++; $display("FAIL flush_hilo: got %h/%h want %h/%h", bus.HI, bus.LO, exp_hi, exp_lo); end
    move_op(3'd4, 32'hDEAD_BEEF, 1'b1);
    total++; if (bus.HI !== exp_hi) begin bad++; $display("FAIL flush_mthi: got %h want %h", bus.HI, exp_hi); end
  endtask

  task automatic test_busy_conflict();
    int n;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.A = 32'hFFFF_FFFF; bus.B = 32'd2; bus.req = 1'b0;
    #1; n = bus.busy ? 1 : 0;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 3'd5; bus.A = 32'h55;
    #1; if (bus.busy) n++;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd3; bus.A = 32'd7; bus.B = 32'd2;
    #1; if (bus.busy) n++;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      idle_inputs();
      #1;
      if (!bus.busy) break;
      n++;
    end
    model(3'd0, 32'hFFFF_FFFF, 32'd2, exp_hi, exp_lo);
    total++; if (n != MULT_N) begin bad++; $display("FAIL conflict_busy_len: got %0d want %0d", n, MULT_N); end
    total++; if (bus.HI !== exp_hi || bus.LO !== exp_lo) begin bad++; $display("FAIL conflict_hilo: got %h/%h want %h/%h", bus.HI, bus.LO, exp_hi, exp_lo); end
  endtask

  task automatic test_random();
    int n, want;
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int k = 0; k < 40; k++) begin
      op = 3'($urandom_range(0, 5));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = 32'($urandom_range(1, 20));
        3:       b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      model(op, a, b, exp_hi, exp_lo);
      if (op < 3'd4) begin
        run_op(op, a, b, n);
        want = (op < 3'd2) ? MULT_N : DIV_N;
        total++; if (n != want) begin bad++; $display("FAIL rand_busy_len[%0d] op=%0d: got %0d want %0d", k, op, n, want); end
      end else begin
        move_op(op, a, 1'b0);
      end
      total++; if (bus.HI !== exp_hi || bus.LO !== exp_lo) begin bad++; $display("FAIL rand_hilo[%0d] op=%0d a=%h b=%h: got %h/%h want %h/%h", k, op, a, b, bus.HI, bus.LO, exp_hi, exp_lo); end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 3'd6; bus.A = '0; bus.B = '0; bus.req = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_flush();
    test_busy_conflict();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Execute-stage multiply/divide unit with the architectural HI/LO registers.
- Sits beside the E-stage ALU and consumes E-stage operands (forwarded rs/rt).
- Drives `E_MDU_busy` into the stall controller; supplies HI/LO data for mfhi/mflo to the E→M pipeline register.
- Models fixed multi-cycle latency so the pipeline stalls realistically on HI/LO hazards.

Parameters:
- MULT_CYCLES, 5, cycles from start to HI/LO update for mult/multu (valid range ≥2).
- DIV_CYCLES, 10, cycles from start to HI/LO update for div/divu (valid range ≥2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  E-stage instruction is mult/multu/div/divu this cycle.
- op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 mfhi, 7 mflo.
- A  input  32  rs operand (forwarded).
- B  input  32  rt operand (forwarded).
- req  input  1  exception/interrupt flush of the E-stage instruction this cycle.
- busy  output  1  combinational: start | (state != IDLE).
- HI  output  32  current HI register.
- LO  output  32  current LO register.
- MDU_out  output  32  op==6 ? HI : LO (combinational, valid for mfhi/mflo).

Behaviour:
- Reset (reset==0, any time, asynchronous):
  - HI=0, LO=0, state=IDLE, cnt=0, temp regs=0.
  - busy=0 unless start=1.
  - An in-flight op is discarded; HI/LO are not updated.
- States: IDLE, RUN. Down-counter `cnt`, width ≥ clog2(max(MULT_CYCLES, DIV_CYCLES)).
- Start (IDLE, start=1, req=0, op∈{0..3}):
  - Compute the result combinationally from A/B and latch it into tempHI/tempLO.
  - cnt ← (op<2 ? MULT_CYCLES : DIV_CYCLES) − 1; state ← RUN.
- RUN:
  - Each edge, cnt ← cnt−1.
  - On the edge where cnt==1: HI←tempHI, LO←tempLO, state←IDLE.
  - busy is therefore high for exactly N cycles, including the start cycle. The new HI/LO is visible in cycle N+1.
- Arithmetic:
  - mult: signed 64-bit product {HI,LO}=$signed(A)*$signed(B).
  - multu: unsigned product.
  - div: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend. 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
  - divu: unsigned quotient and remainder.
  - B==0 for div/divu: the operation still runs for its full latency and holds busy. At completion HI/LO keep their previous values (no update).
- mthi/mtlo (op 4/5, start=0, req=0, state==IDLE): HI or LO ← A at the next edge; single cycle; busy not raised.
- mthi/mtlo while state==RUN: ignored. The stall controller prevents this case; the block guarantees the in-flight result wins.
- start=1 while state==RUN: ignored, no restart. The stall controller prevents this case.
- req=1 together with start or mthi/mtlo: no effect. No state change; HI/LO unchanged.
- req=1 during RUN: no effect. An already-started op completes, because it belongs to an older, committed instruction.
- start=1 with op∉{0..3}: treated as start=0, except busy still follows the start input combinationally.
- mfhi/mflo: MDU_out is purely combinational from HI/LO. No internal bypass of the pending temp result.

Test Plan:
- Reset: hold reset=0 mid-RUN (after mult start) → HI=LO=0, busy=0 immediately (start=0), no later update after reset=1.
- mult latency: A=0xFFFFFFFF, B=2, op=0 start for 1 cycle → busy high for 5 cycles. Cycle 6: HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu with the same operands → HI=1, LO=0xFFFFFFFE.
- div signs:
  - A=−7 (0xFFFFFFF9), B=2, op=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu A=7, B=2 → LO=3, HI=1.
  - A=0x80000000, B=0xFFFFFFFF div → LO=0x80000000, HI=0.
- Divide by zero: preload HI=0x11, LO=0x22 via mthi/mtlo, then div with B=0 → busy 10 cycles, HI=0x11, LO=0x22 afterwards.
- Flush: start=1, op=0, req=1 same cycle → busy=1 that cycle only, state stays IDLE, HI/LO unchanged. mthi with req=1 → HI unchanged.
- Busy conflicts: during RUN of a mult, apply mtlo A=0x55 and a second start of divu → both ignored; final HI/LO equal the first mult result; busy deasserts after exactly 5 cycles from the original start.
